// File: rtl/mac_pkg.sv
// mac_pkg: shared widths and flush-state encoding for the MAC output collector.
package mac_pkg;
    localparam int FP16_W   = 16;
    localparam int LANES    = 4;
    localparam int WB_WIDTH = 64;
    typedef enum logic [1:0] {ST_IDLE, ST_PUSH, ST_DRAIN, ST_DONE} flush_state_t;
endpackage

// File: rtl/mac_wb_fifo.sv
// mac_wb_fifo: show-ahead write-back FIFO, wrap-bit pointers, retroactive last-marking of the tail entry.
module mac_wb_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 65
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  logic [W-1:0]           i_data,
    input  logic                   i_pop,
    input  logic                   i_mark,
    output logic                   o_empty,
    output logic                   o_full,
    output logic [$clog2(DEPTH):0] o_count,
    output logic [W-1:0]           o_head
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [AW:0]   wp, rp;
    logic [AW-1:0] tail;
    assign tail    = wp[AW-1:0] - AW'(1);
    assign o_count = wp - rp;
    assign o_empty = wp == rp;
    assign o_full  = wp[AW] != rp[AW] && wp[AW-1:0] == rp[AW-1:0];
    assign o_head  = o_empty ? '0 : mem[rp[AW-1:0]];
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (i_push) wp <= wp + (AW+1)'(1);
            if (i_pop) rp <= rp + (AW+1)'(1);
        end
    end
    // Storage is not reset; o_head is gated by o_empty instead.
    always_ff @(posedge i_clk) begin
        if (i_push) mem[wp[AW-1:0]] <= i_data;
        else if (i_mark && !o_empty) mem[tail][W-1] <= 1'b1;
    end
endmodule

// File: rtl/mac_out_collector.sv
// mac_out_collector: packs FP16 results into 64-bit write-back words with end-of-tile flush.
// Optional MAC_COLL_RELU_EN: negative samples are stored as zero.
module mac_out_collector
    import mac_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int LANES = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_valid,
    input  logic [FP16_W-1:0]   i_conv,
    output logic                o_inhibit,
    input  logic                i_flush,
    output logic                o_wb_valid,
    output logic [WB_WIDTH-1:0] o_wb_data,
    output logic                o_wb_last,
    input  logic                i_wb_ready,
    output logic                o_flush_done
);
    localparam int LW = $clog2(LANES);
    localparam int AW = $clog2(DEPTH);
    flush_state_t                 state, state_nx;
    logic [LW-1:0]                cnt;
    logic [LANES-2:0][FP16_W-1:0] pack;
    logic [FP16_W-1:0]            sample;
    logic [WB_WIDTH:0]            word_in, head;
    logic [AW:0]                  count;
    logic accept, full_word, push_part, push, pop, mark, empty, full;
`ifdef MAC_COLL_RELU_EN
    assign sample = i_conv[FP16_W-1] ? '0 : i_conv;
`else
    assign sample = i_conv;
`endif
    assign o_inhibit    = (full && cnt == LW'(LANES-1)) || state != ST_IDLE;
    assign accept       = i_valid && !o_inhibit;
    assign full_word    = accept && cnt == LW'(LANES-1);
    assign push_part    = state == ST_PUSH && cnt != '0 && !full;
    assign push         = full_word || push_part;
    assign mark         = state == ST_PUSH && cnt == '0;
    assign pop          = !empty && i_wb_ready;
    assign word_in      = {push_part, full_word ? sample : {FP16_W{1'b0}}, pack};
    assign o_wb_valid   = !empty;
    assign o_wb_data    = head[WB_WIDTH-1:0];
    // A marked tail popped in the marking cycle must still leave with last set.
    assign o_wb_last    = head[WB_WIDTH] || (mark && count == (AW+1)'(1));
    assign o_flush_done = state == ST_DONE;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            pack  <= '0;
        end else begin
            state <= state_nx;
            if (push) begin
                cnt  <= '0;
                pack <= '0;
            end else if (accept) begin
                pack[cnt] <= sample;
                cnt       <= cnt + LW'(1);
            end
        end
    end
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  state_nx = i_flush ? ST_PUSH : ST_IDLE;
            ST_PUSH:  state_nx = (cnt == '0 || !full) ? ST_DRAIN : ST_PUSH;
            ST_DRAIN: state_nx = empty ? ST_DONE : ST_DRAIN;
            default:  state_nx = ST_IDLE;
        endcase
    end
    mac_wb_fifo #(.DEPTH(DEPTH), .W(WB_WIDTH+1)) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (push),
        .i_data  (word_in),
        .i_pop   (pop),
        .i_mark  (mark),
        .o_empty (empty),
        .o_full  (full),
        .o_count (count),
        .o_head  (head)
    );
endmodule

// File: tb/tb_mac_out_collector.sv
// tb_mac_out_collector: directed self-checking bench for mac_out_collector (DEPTH=8).
module tb_mac_out_collector;
    logic        i_clk = 0, i_rst = 1, i_valid = 0, i_flush = 0, i_wb_ready = 0;
    logic [15:0] i_conv = '0;
    logic        o_inhibit, o_wb_valid, o_wb_last, o_flush_done;
    logic [63:0] o_wb_data;
    int          n_chk = 0, n_fail = 0, n_done = 0;
    logic [64:0] popped[$];
    logic [64:0] exp_w;
    logic [15:0] b;
    logic        acc;

    mac_out_collector #(.DEPTH(8), .LANES(4)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_valid      (i_valid),
        .i_conv       (i_conv),
        .o_inhibit    (o_inhibit),
        .i_flush      (i_flush),
        .o_wb_valid   (o_wb_valid),
        .o_wb_data    (o_wb_data),
        .o_wb_last    (o_wb_last),
        .i_wb_ready   (i_wb_ready),
        .o_flush_done (o_flush_done)
    );

    always #5 i_clk = ~i_clk;

    // Words leaving the FIFO, recorded half a cycle before the popping edge.
    always @(negedge i_clk) begin
        if (o_wb_valid && i_wb_ready && !i_rst) popped.push_back({o_wb_last, o_wb_data});
        if (o_flush_done) n_done++;
    end

    task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic send(input logic [15:0] s);
        i_valid = 1;
        i_conv  = s;
        tick();
        i_valid = 0;
    endtask

    task automatic drain;
        i_wb_ready = 1;
        for (int i = 0; i < 40 && o_wb_valid; i++) tick();
        check("drain_empty", o_wb_valid, 0);
    endtask

    initial begin
        tick();
        tick();
        check("rst_valid", o_wb_valid, 0);
        check("rst_data", o_wb_data, 0);
        check("rst_last", o_wb_last, 0);
        check("rst_done", o_flush_done, 0);
        check("rst_inhibit", o_inhibit, 0);
        i_rst = 0;

        // Single full word
        i_wb_ready = 1;
        popped.delete();
        send(16'h3C00); send(16'h4000); send(16'h4200);
        check("t1_not_yet", o_wb_valid, 0);
        send(16'h4400);
        check("t1_valid", o_wb_valid, 1);
        check("t1_data", o_wb_data, 64'h4400_4200_4000_3C00);
        check("t1_last", o_wb_last, 0);
        tick();
        check("t1_popped_valid", o_wb_valid, 0);
        check("t1_count", popped.size(), 1);

        // Backpressure: 35 samples fill FIFO and leave 3 lanes pending
        i_wb_ready = 0;
        popped.delete();
        for (int k = 0; k < 35; k++) send(16'h1000 + 16'(k));
        check("t2_inhibit", o_inhibit, 1);
        check("t2_head", o_wb_data, 64'h1003_1002_1001_1000);
        i_valid = 1;
        i_conv  = 16'h1023;
        tick();
        check("t2_held", o_inhibit, 1);
        i_wb_ready = 1;
        acc = 0;
        for (int i = 0; i < 10 && !acc; i++) begin
            acc = !o_inhibit;
            tick();
        end
        i_valid = 0;
        check("t2_accept", acc, 1);
        drain();
        check("t2_count", popped.size(), 9);
        for (int w = 0; w < 9; w++) begin
            b = 16'h1000 + 16'(4 * w);
            exp_w = {1'b0, b + 16'd3, b + 16'd2, b + 16'd1, b};
            check($sformatf("t2_word%0d", w), popped[w], exp_w);
        end

        // Flush with partial word; second flush while busy is ignored
        i_wb_ready = 0;
        popped.delete();
        n_done = 0;
        for (int k = 0; k < 6; k++) send(16'h2000 + 16'(k));
        i_flush = 1;
        tick();
        i_flush = 0;
        check("t3_inhibit", o_inhibit, 1);
        tick(); tick();
        i_flush = 1;
        tick();
        i_flush = 0;
        tick();
        check("t3_no_done_yet", o_flush_done, 0);
        i_wb_ready = 1;
        for (int i = 0; i < 20 && !o_flush_done; i++) tick();
        check("t3_done", o_flush_done, 1);
        check("t3_count", popped.size(), 2);
        check("t3_word0", popped[0], {1'b0, 64'h2003_2002_2001_2000});
        check("t3_word1", popped[1], {1'b1, 64'h0000_0000_2005_2004});
        tick();
        check("t3_done_pulse", o_flush_done, 0);
        repeat (5) tick();
        check("t3_done_once", n_done, 1);
        check("t3_idle", o_inhibit, 0);

        // Flush with nothing pending
        popped.delete();
        n_done = 0;
        i_flush = 1;
        tick();
        i_flush = 0;
        check("t4_c1", o_flush_done, 0);
        tick();
        check("t4_c2", o_flush_done, 0);
        tick();
        check("t4_c3", o_flush_done, 1);
        tick();
        check("t4_c4", o_flush_done, 0);
        check("t4_no_word", popped.size(), 0);
        check("t4_once", n_done, 1);

        // Sample in the flush cycle completes a word, which must carry last
        i_wb_ready = 0;
        popped.delete();
        send(16'h3000); send(16'h3001); send(16'h3002);
        i_valid = 1;
        i_conv  = 16'h3003;
        i_flush = 1;
        tick();
        i_valid = 0;
        i_flush = 0;
        repeat (3) tick();
        check("t5_last_marked", o_wb_last, 1);
        drain();
        check("t5_count", popped.size(), 1);
        check("t5_word", popped[0], {1'b1, 64'h3003_3002_3001_3000});
        repeat (3) tick();

        // Negative samples
        i_wb_ready = 1;
        popped.delete();
        send(16'hBC00); send(16'h3C00); send(16'h8001); send(16'h0001);
        tick();
        check("t6_count", popped.size(), 1);
`ifdef MAC_COLL_RELU_EN
        check("t6_word", popped[0], {1'b0, 64'h0001_0000_3C00_0000});
`else
        check("t6_word", popped[0], {1'b0, 64'h0001_8001_3C00_BC00});
`endif

        // Reset during drain
        i_wb_ready = 0;
        popped.delete();
        n_done = 0;
        for (int k = 0; k < 12; k++) send(16'h4000 + 16'(k));
        i_flush = 1;
        tick();
        i_flush = 0;
        tick(); tick();
        check("t7_queued", o_wb_valid, 1);
        i_rst = 1;
        tick();
        i_rst = 0;
        check("t7_valid", o_wb_valid, 0);
        check("t7_data", o_wb_data, 0);
        check("t7_inhibit", o_inhibit, 0);
        repeat (5) tick();
        check("t7_no_done", n_done, 0);
        i_wb_ready = 1;
        send(16'h5000); send(16'h5001); send(16'h5002); send(16'h5003);
        tick();
        check("t7_count", popped.size(), 1);
        check("t7_word", popped[0], {1'b0, 64'h5003_5002_5001_5000});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mac_out_collector.md
MAC_OUT_COLLECTOR -- requirements
Module: mac_out_collector

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning write-back FIFO depth in 64-bit words (power of 2, >=2).
REQ-002 SHALL have parameter LANES, default 4, meaning FP16 results packed per word (fixed 4 in this revision).
REQ-003 SHALL have port i_clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port i_rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port i_valid  input  1  stage-5 result valid.
REQ-006 SHALL have port i_conv  input  16  stage-5 FP16 result.
REQ-007 SHALL have port o_inhibit  output  1  stall to stage 5 (drives its i_inhibit).
REQ-008 SHALL have port i_flush  input  1  single-cycle pulse, end of tile.
REQ-009 SHALL have port o_wb_valid  output  1  write-back word available.
REQ-010 SHALL have port o_wb_data  output  64  packed word, lane 0 in [15:0], lane 3 in [63:48].
REQ-011 SHALL have port o_wb_last  output  1  word is final word of a flush.
REQ-012 SHALL have port i_wb_ready  input  1  downstream accepts word.
REQ-013 SHALL have port o_flush_done  output  1  one-cycle pulse, flush complete.

Function
REQ-014 Sample SHALL be accepted in a cycle iff i_valid=1 and o_inhibit=0; stage 5 holds o_conv/o_valid while inhibited.
REQ-015 Accepted samples SHALL fill lanes in order 0..3 via 2-bit lane counter; the 4th acceptance pushes the word into the FIFO on the same edge, counter wraps 3->0, packer clears.
REQ-016 o_inhibit SHALL be combinational from registers only: (FIFO full and lane counter==3) or flush FSM not IDLE; no path from i_wb_ready or i_valid.
REQ-017 Push SHALL never occur while FIFO full; pop occurs iff o_wb_valid and i_wb_ready; simultaneous push/pop keeps occupancy unchanged.
REQ-018 FIFO SHALL be show-ahead: o_wb_valid/o_wb_data/o_wb_last reflect head entry; a word pushed at edge N is visible after edge N when FIFO was empty (latency 1 cycle from 4th sample to o_wb_valid).
REQ-019 Pointers SHALL carry wrap bit; full = addresses equal, wrap bits differ; empty = pointers equal.
REQ-020 Flush FSM states IDLE, PUSH, DRAIN, DONE: IDLE->PUSH on i_flush; PUSH->DRAIN when partial word pushed (lane counter>0, FIFO not full; unused lanes zero, last=1) or immediately if lane counter==0 (then last=1 on the most recent pushed word still in FIFO, else no word marked); DRAIN->DONE when FIFO empty; DONE asserts o_flush_done one cycle ->IDLE.
REQ-021 A sample accepted in the i_flush cycle SHALL be included before the flush; if it completes a word, that word carries last=1 and PUSH pushes nothing.
REQ-022 i_flush while FSM not IDLE SHALL be ignored.

Reset
REQ-023 On i_rst: pointers, occupancy, lane counter, packer, FSM=IDLE cleared; o_wb_valid=0, o_wb_last=0, o_wb_data=0, o_flush_done=0, o_inhibit=0 from next cycle; in-flight data discarded, reset mid-flush returns to IDLE without o_flush_done.

Configuration
REQ-024 With MAC_COLL_RELU_EN defined, accepted samples with bit15=1 SHALL be stored as 16'h0000; without it, samples stored unmodified.

Structure
REQ-025 Shared package mac_pkg SHALL hold FP16 width (16), LANES, WB_WIDTH (64), flush-state typedef.
REQ-026 FIFO SHALL be sub-module mac_wb_fifo (DEPTH x 65 bits, data+last); packer and FSM in top.

Verification
REQ-027 Accept 4 samples 16'h3C00,16'h4000,16'h4200,16'h4400, i_wb_ready=1 -> one word 64'h4400_4200_4000_3C00, o_wb_valid 1 cycle after 4th sample, last=0.
REQ-028 i_wb_ready=0, stream 8*4+3=35 samples (DEPTH=8) -> o_inhibit=1 with lane counter 3; 36th held; raise ready -> 36th accepted, no loss, order preserved.
REQ-029 6 samples then i_flush -> 2 words, second 64'h0000_0000_s5_s4, last=1; o_flush_done after both popped.
REQ-030 i_flush with lane counter 0 and FIFO empty -> o_flush_done 2 cycles later, no word emitted.
REQ-031 With MAC_COLL_RELU_EN, sample 16'hBC00 -> lane value 16'h0000; without it -> 16'hBC00.
REQ-032 Assert i_rst during DRAIN with 3 words queued -> o_wb_valid=0 next cycle, no o_flush_done, next 4 samples produce a fresh word.
